// File: rtl/instr_mem.sv
// Instruction memory with a byte-serial loader. Words are assembled MSB-first,
// written one per WRITE cycle, and fetched through a registered read port.
module instr_mem #(
  parameter int                     ADDR_WIDTH    = 8,
  parameter int                     DEPTH         = 256,
  parameter int                     INSTR_WIDTH   = 28,
  parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = {INSTR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  input  logic                   iLoadEnable,
  input  logic                   iLoadValid,
  input  logic [7:0]             iLoadByte,
  output logic                   oLoadReady,
  output logic                   oLoadDone,
  output logic [ADDR_WIDTH:0]    oLoadCount
);

  localparam int BPW    = (INSTR_WIDTH + 7) / 8;
  localparam int ASM_W  = BPW * 8;
  localparam int BCNT_W = $clog2(BPW) + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [BCNT_W-1:0]   LAST_BYTE  = BCNT_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [BCNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]         asm_q, asm_d;
  logic [ADDR_WIDTH:0]      load_count_q, load_count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic                     mem_we;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_idx;
  logic                     rd_in_range;

  logic [INSTR_WIDTH-1:0]   mem [DEPTH];

  // The write address always equals the number of words written this session.
  assign wr_idx      = load_count_q[IDX_W-1:0];
  assign rd_idx      = iAddress[IDX_W-1:0];
  assign rd_in_range = ({1'b0, iAddress} < DEPTH_W);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    load_count_d = load_count_q;
    valid_d      = valid_q;
    mem_we       = 1'b0;

    if (!iLoadEnable) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = ASSEMBLE;
          byte_cnt_d   = '0;
          load_count_d = '0;
          valid_d      = '0;
        end
        ASSEMBLE: begin
          if (iLoadValid) begin
            asm_d = (asm_q << 8) | ASM_W'(iLoadByte);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = WRITE;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          mem_we          = 1'b1;
          valid_d[wr_idx] = 1'b1;
          load_count_d    = load_count_q + 1'b1;
          state_d         = ((load_count_q + 1'b1) == DEPTH_W) ? DONE : ASSEMBLE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Fetches are blanked while the loader owns the memory.
  always_comb begin
    instr_d = DEFAULT_INSTR;
    if (state_q == IDLE && rd_in_range && valid_q[rd_idx]) begin
      instr_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      load_count_q <= '0;
      valid_q      <= '0;
      instr_q      <= DEFAULT_INSTR;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      load_count_q <= load_count_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= asm_q[INSTR_WIDTH-1:0];
    end
  end

  assign oInstruction = instr_q;
  assign oLoadReady   = (state_q == ASSEMBLE);
  assign oLoadDone    = (state_q == DONE);
  assign oLoadCount   = load_count_q;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem with a 4-word memory, 3-bit addresses and a
// non-zero default word so blanked fetches are distinguishable from zeros.
module tb_instr_mem;

  localparam int                ADDR_WIDTH = 3;
  localparam int                DEPTH      = 4;
  localparam int                IW         = 28;
  localparam logic [IW-1:0]     DEF        = 28'h5A5A5A5;

  logic                  clk;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [IW-1:0]         oInstruction;
  logic                  iLoadEnable;
  logic                  iLoadValid;
  logic [7:0]            iLoadByte;
  logic                  oLoadReady;
  logic                  oLoadDone;
  logic [ADDR_WIDTH:0]   oLoadCount;

  int checks;
  int failures;

  instr_mem #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DEPTH        (DEPTH),
    .INSTR_WIDTH  (IW),
    .DEFAULT_INSTR(DEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iAddress    (iAddress),
    .oInstruction(oInstruction),
    .iLoadEnable (iLoadEnable),
    .iLoadValid  (iLoadValid),
    .iLoadByte   (iLoadByte),
    .oLoadReady  (oLoadReady),
    .oLoadDone   (oLoadDone),
    .oLoadCount  (oLoadCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch an address and check the word that appears one cycle later.
  task automatic applyStimulus(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                               input logic [IW-1:0] expected);
    iAddress = addr;
    tick();
    checkOutput(tag, 32'(oInstruction), 32'(expected));
  endtask

  // Byte 0 carries junk in its top nibble, which the memory must drop.
  task automatic sendBytes(input logic [IW-1:0] word, input int count);
    logic [31:0] full;
    full = {4'hF, word};
    for (int i = 0; i < count; i++) begin
      iLoadValid = 1'b1;
      iLoadByte  = full[31 - 8*i -: 8];
      tick();
    end
    iLoadValid = 1'b0;
  endtask

  task automatic loadWord(input logic [IW-1:0] word);
    sendBytes(word, 4);
    tick();
  endtask

  task automatic startSession();
    iLoadEnable = 1'b1;
    tick();
  endtask

  task automatic endSession();
    iLoadEnable = 1'b0;
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    iAddress    = '0;
    iLoadEnable = 1'b0;
    iLoadValid  = 1'b0;
    iLoadByte   = 8'h00;
    repeat (2) tick();

    checkOutput("rst_instr", 32'(oInstruction), 32'(DEF));
    checkOutput("rst_ready", 32'(oLoadReady), 32'd0);
    checkOutput("rst_done",  32'(oLoadDone),  32'd0);
    checkOutput("rst_count", 32'(oLoadCount), 32'd0);

    #2 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      applyStimulus("post_rst_fetch", ADDR_WIDTH'(a), DEF);
    end

    $display("[TB] single word load");
    startSession();
    checkOutput("assemble_ready", 32'(oLoadReady), 32'd1);
    sendBytes(28'h1234567, 4);
    checkOutput("write_ready_low", 32'(oLoadReady), 32'd0);
    tick();
    endSession();
    checkOutput("one_word_count", 32'(oLoadCount), 32'd1);
    applyStimulus("fetch0_word", 3'd0, 28'h1234567);
    iAddress = 3'd1;
    checkOutput("latency_hold", 32'(oInstruction), 32'h1234567);
    applyStimulus("fetch1_unwritten", 3'd1, DEF);

    $display("[TB] partial word discard");
    startSession();
    loadWord(28'h0A1B2C3);
    loadWord(28'h7654321);
    sendBytes(28'h0FEDCBA, 2);
    endSession();
    checkOutput("partial_count", 32'(oLoadCount), 32'd2);
    applyStimulus("partial_fetch0", 3'd0, 28'h0A1B2C3);
    applyStimulus("partial_fetch1", 3'd1, 28'h7654321);
    applyStimulus("partial_fetch2", 3'd2, DEF);

    $display("[TB] fill and overflow");
    startSession();
    iAddress = 3'd1;
    loadWord(28'h1111111);
    loadWord(28'h2222222);
    checkOutput("fetch_during_load", 32'(oInstruction), 32'(DEF));
    loadWord(28'h3333333);
    checkOutput("not_done_yet", 32'(oLoadDone), 32'd0);
    loadWord(28'h4444444);
    checkOutput("done_after_fill", 32'(oLoadDone), 32'd1);
    checkOutput("fill_count", 32'(oLoadCount), 32'd4);
    checkOutput("done_ready_low", 32'(oLoadReady), 32'd0);
    loadWord(28'h5555555);
    checkOutput("overflow_count", 32'(oLoadCount), 32'd4);
    checkOutput("done_fetch_blank", 32'(oInstruction), 32'(DEF));
    endSession();
    checkOutput("done_cleared", 32'(oLoadDone), 32'd0);
    applyStimulus("fill_fetch0", 3'd0, 28'h1111111);
    applyStimulus("fill_fetch1", 3'd1, 28'h2222222);
    applyStimulus("fill_fetch2", 3'd2, 28'h3333333);
    applyStimulus("fill_fetch3", 3'd3, 28'h4444444);
    applyStimulus("fill_fetch4_oor", 3'd4, DEF);
    applyStimulus("fill_fetch7_oor", 3'd7, DEF);

    $display("[TB] new session clears valid bits");
    startSession();
    loadWord(28'h0000AAA);
    loadWord(28'h0000BBB);
    loadWord(28'h0000CCC);
    endSession();
    startSession();
    loadWord(28'h9876543);
    endSession();
    checkOutput("reload_count", 32'(oLoadCount), 32'd1);
    applyStimulus("reload_fetch1", 3'd1, DEF);
    applyStimulus("reload_fetch2", 3'd2, DEF);
    applyStimulus("reload_fetch0", 3'd0, 28'h9876543);

    $display("[TB] async reset mid-word");
    startSession();
    loadWord(28'h0C0FFEE);
    sendBytes(28'h0BADBAD, 2);
    iLoadValid = 1'b1;
    iLoadByte  = 8'h99;
    checkOutput("pre_rst_ready", 32'(oLoadReady), 32'd1);
    checkOutput("pre_rst_count", 32'(oLoadCount), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ready", 32'(oLoadReady), 32'd0);
    checkOutput("async_rst_count", 32'(oLoadCount), 32'd0);
    checkOutput("async_rst_done",  32'(oLoadDone),  32'd0);
    checkOutput("async_rst_instr", 32'(oInstruction), 32'(DEF));
    iLoadValid  = 1'b0;
    iLoadEnable = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    applyStimulus("after_rst_fetch0", 3'd0, DEF);
    applyStimulus("after_rst_fetch1", 3'd1, DEF);
    checkOutput("after_rst_ready", 32'(oLoadReady), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 8, fetch/write address width.
REQ-002 SHALL provide parameter DEPTH, default 256, number of instruction words (DEPTH <= 2^ADDR_WIDTH).
REQ-003 SHALL provide parameter INSTR_WIDTH, default 28, instruction word width.
REQ-004 SHALL provide parameter DEFAULT_INSTR, default {INSTR_WIDTH{1'b0}}, word returned for unwritten, out-of-range or blocked fetches.
REQ-005 SHALL derive BPW = ceil(INSTR_WIDTH/8) bytes per word.
REQ-006 Clock  input  1  single clock; all state updates on its rising edge.
REQ-007 Reset  input  1  reset, asynchronous, active-low.
REQ-008 iAddress  input  ADDR_WIDTH  fetch address.
REQ-009 oInstruction  output  INSTR_WIDTH  registered fetched instruction.
REQ-010 iLoadEnable  input  1  level; high selects load mode.
REQ-011 iLoadValid  input  1  byte strobe for iLoadByte.
REQ-012 iLoadByte  input  8  loader byte, MSB-first within a word.
REQ-013 oLoadReady  output  1  high when a byte is accepted this cycle if iLoadValid is high.
REQ-014 oLoadDone  output  1  high once DEPTH words have been written, until reset or iLoadEnable low.
REQ-015 oLoadCount  output  ADDR_WIDTH+1  number of complete words written in the current load session.

Function
REQ-016 Loader FSM states: IDLE, ASSEMBLE, WRITE, DONE.
REQ-017 IDLE: oLoadReady=0; iLoadEnable=1 -> ASSEMBLE, with write address, byte counter and oLoadCount cleared to 0.
REQ-018 ASSEMBLE: oLoadReady=1; on iLoadValid the byte shifts into the assembly register (shift left 8) and the byte counter increments; the BPW-th byte -> WRITE.
REQ-019 Assembly register: SHALL be BPW*8 bits; SHALL store its low INSTR_WIDTH bits; SHALL discard its excess MSBs (top 4 bits of byte 0 for INSTR_WIDTH=28).
REQ-020 WRITE (exactly one cycle, oLoadReady=0): SHALL write the word at the write address, set its valid bit, increment the write address and oLoadCount; -> DONE if oLoadCount becomes DEPTH, else -> ASSEMBLE.
REQ-021 DONE: oLoadReady=0, oLoadDone=1; bytes ignored; the write address SHALL NOT wrap.
REQ-022 iLoadEnable low in any state -> IDLE on next edge; a partial word SHALL be discarded and not written; oLoadDone->0; oLoadCount and valid bits hold.
REQ-023 A new session (IDLE->ASSEMBLE) SHALL clear all valid bits in the same cycle.
REQ-024 Fetch: oInstruction SHALL update one clock after iAddress (1-cycle latency), registered.
REQ-025 The fetch value SHALL be mem[iAddress] if iAddress < DEPTH and valid[iAddress]=1, else DEFAULT_INSTR.
REQ-026 While FSM != IDLE, oInstruction SHALL be DEFAULT_INSTR, so the CPU fetches the default word during loading.
REQ-027 Memory array contents SHALL NOT be reset; only valid bits, FSM, counters and outputs are reset.
REQ-028 iLoadValid outside ASSEMBLE SHALL have no effect.

Reset
REQ-029 On Reset low, asynchronously: FSM=IDLE, oInstruction=DEFAULT_INSTR, oLoadReady=0, oLoadDone=0, oLoadCount=0, byte counter=0, all valid bits=0.
REQ-030 Reset asserted mid-load SHALL abort the load; after release, every address SHALL fetch DEFAULT_INSTR until a reload.
REQ-031 After Reset release, the FSM SHALL enter ASSEMBLE no earlier than the first rising edge with iLoadEnable=1.

Verification
REQ-032 Reset, then fetch addr 0..3 -> oInstruction=DEFAULT_INSTR each, 1-cycle latency.
REQ-033 Load bytes 0xF1,0x23,0x45,0x67, then drop iLoadEnable; fetch addr 0 -> 28'h1234567; oLoadCount=1; oLoadReady low in the WRITE cycle.
REQ-034 Load 2.5 words, then drop iLoadEnable -> oLoadCount=2; addr 2 fetches DEFAULT_INSTR; addr 1 fetches the second word.
REQ-035 DEPTH=4: load 5 words -> oLoadDone=1 after the 4th WRITE; the 5th word is ignored; addr 4 (out of range) and all fetches during load return DEFAULT_INSTR; addr 0..3 correct after iLoadEnable low.
REQ-036 Load 3 words, then start a new session and load 1 word -> addr 1,2 fetch DEFAULT_INSTR; addr 0 is the new word.
REQ-037 Assert Reset mid-word with iLoadValid active -> outputs go to reset values immediately with no clock edge; all fetches return DEFAULT_INSTR.
